// File: rtl/prpg_pkg.sv
// Shared types for the PRPG engine: instruction opcodes, controller states and
// LFSR feedback modes.
package prpg_pkg;

  typedef enum logic [3:0] {
    OP_HALT      = 4'd0,
    OP_CONFIG    = 4'd1,
    OP_INIT      = 4'd2,
    OP_RUN       = 4'd3,
    OP_INIT_ADDR = 4'd4,
    OP_ST_P      = 4'd5,
    OP_ADD_ADDR  = 4'd6,
    OP_LD_P      = 4'd7,
    OP_ST_HD     = 4'd8,
    OP_MODE      = 4'd9
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  typedef enum logic {
    MODE_GALOIS    = 1'b0,
    MODE_FIBONACCI = 1'b1
  } mode_e;

endpackage

// File: rtl/prpg_step.sv
// One LFSR step (Galois or Fibonacci) of pattern P under tap mask, plus the
// Hamming distance between the current and next pattern.
module prpg_step
  import prpg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [0:W-1]           P,
  input  logic [W-2:0]           tap,
  input  mode_e                  mode,
  output logic [0:W-1]           P_next,
  output logic [$clog2(W+1)-1:0] hd
);

  localparam int HW = $clog2(W+1);

  logic         w_fb;
  logic [0:W-1] w_diff;

  always_comb begin
    // NOTE: blocking assignments in combinational logic; w_fb is a running XOR
    // that must see its own update within the same evaluation.
    P_next = '0;
    w_fb   = P[W-1];
    if (mode == MODE_GALOIS) begin
      P_next[0] = P[W-1];
      for (int i = 1; i < W; i++) begin
        P_next[i] = P[i-1] ^ (tap[W-1-i] & P[W-1]);
      end
    end else begin
      for (int i = 1; i < W; i++) begin
        w_fb      = w_fb ^ (tap[W-1-i] & P[i-1]);
        P_next[i] = P[i-1];
      end
      P_next[0] = w_fb;
    end
  end

  assign w_diff = P ^ P_next;

  always_comb begin
    hd = '0;
    for (int i = 0; i < W; i++) begin
      hd = hd + HW'(w_diff[i]);
    end
  end

endmodule

// File: rtl/prpg_engine.sv
// Programmable pseudo-random pattern generator: a tiny instruction sequencer
// driving an LFSR pattern register and a small scratch memory.
module prpg_engine
  import prpg_pkg::*;
#(
  parameter int W   = 8,
  parameter int AW  = 8,
  parameter int PCW = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [W+3:0]           instr,
  output logic [PCW-1:0]         pc,
  output logic [0:W-1]           P,
  output logic [0:W-1]           P_next,
  output logic [$clog2(W+1)-1:0] hd,
  output logic                   busy,
  output logic                   halted
);

  localparam int HW = $clog2(W+1);

  state_e         r_state, w_state_nxt;
  logic [PCW-1:0] r_pc, w_pc_nxt;
  logic [0:W-1]   r_p, w_p_nxt;
  logic [W-2:0]   r_tap, w_tap_nxt;
  mode_e          r_mode, w_mode_nxt;
  logic [AW-1:0]  r_addr, w_addr_nxt;
  logic [W-1:0]   r_cnt, w_cnt_nxt;
  logic [W-1:0]   r_mem [0:2**AW-1];

  logic           w_mem_we;
  logic [W-1:0]   w_mem_wdata;
  logic [3:0]     w_opcode;
  logic [W-1:0]   w_operand;
  logic [0:W-1]   w_p_step;
  logic [HW-1:0]  w_hd;

  prpg_step #(.W(W)) u_step (
    .P      (r_p),
    .tap    (r_tap),
    .mode   (r_mode),
    .P_next (w_p_step),
    .hd     (w_hd)
  );

  assign w_opcode  = instr[W+3:W];
  assign w_operand = instr[W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_p_nxt     = r_p;
    w_tap_nxt   = r_tap;
    w_mode_nxt  = r_mode;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_mem_wdata = '0;
    busy        = (r_state == ST_EXEC) || (r_state == ST_RUN);
    halted      = (r_state == ST_HALT);

    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          w_state_nxt = ST_EXEC;
          w_pc_nxt    = '0;
        end
      end
      ST_EXEC: begin
        w_pc_nxt = r_pc + PCW'(1);
        case (w_opcode)
          OP_HALT:      w_state_nxt = ST_HALT;
          OP_CONFIG:    w_tap_nxt   = w_operand[W-2:0];
          OP_INIT:      w_p_nxt     = w_operand;
          OP_RUN: begin
            // The decode cycle is step 1; r_cnt holds the steps still owed.
            w_p_nxt = w_p_step;
            if (w_operand > W'(1)) begin
              w_cnt_nxt   = w_operand - W'(1);
              w_state_nxt = ST_RUN;
              w_pc_nxt    = r_pc;
            end
          end
          OP_INIT_ADDR: w_addr_nxt  = w_operand[AW-1:0];
          OP_ST_P: begin
            w_mem_we    = 1'b1;
            w_mem_wdata = r_p;
          end
          OP_ADD_ADDR:  w_addr_nxt  = r_addr + w_operand[AW-1:0];
          OP_LD_P:      w_p_nxt     = r_mem[r_addr];
          OP_ST_HD: begin
            w_mem_we    = 1'b1;
            w_mem_wdata = W'(w_hd);
          end
          OP_MODE:      w_mode_nxt  = mode_e'(w_operand[0]);
          default: ;
        endcase
      end
      ST_RUN: begin
        w_p_nxt   = w_p_step;
        w_cnt_nxt = r_cnt - W'(1);
        if (r_cnt == W'(1)) begin
          w_state_nxt = ST_EXEC;
          w_pc_nxt    = r_pc + PCW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_p     <= '0;
      r_tap   <= '0;
      r_mode  <= MODE_GALOIS;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_p     <= w_p_nxt;
      r_tap   <= w_tap_nxt;
      r_mode  <= w_mode_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: the scratch memory has no reset so it can map onto plain RAM; the
  // asynchronous read makes a write visible to a load on the very next cycle.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= w_mem_wdata;
    end
  end

  assign pc     = r_pc;
  assign P      = r_p;
  assign P_next = w_p_step;
  assign hd     = w_hd;

endmodule

// File: tb/tb_prpg_engine.sv
// Directed bench for prpg_engine: three short programs from a bench-held ROM,
// checked cycle by cycle on the falling clock edge.
module tb_prpg_engine;
  import prpg_pkg::*;

  localparam int W   = 8;
  localparam int AW  = 8;
  localparam int PCW = 6;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W+3:0]   instr;
  logic [PCW-1:0] pc;
  logic [0:W-1]   P;
  logic [0:W-1]   P_next;
  logic [3:0]     hd;
  logic           busy;
  logic           halted;

  logic [W+3:0]   rom [0:2**PCW-1];
  logic [7:0]     rot_exp [0:7];

  int n_checks = 0;
  int n_errors = 0;

  prpg_engine #(.W(W), .AW(AW), .PCW(PCW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .instr  (instr),
    .pc     (pc),
    .P      (P),
    .P_next (P_next),
    .hd     (hd),
    .busy   (busy),
    .halted (halted)
  );

  assign instr = rom[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [W+3:0] mk(input logic [3:0] op, input logic [W-1:0] opd);
    return {op, opd};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 2**PCW; i++) rom[i] = mk(4'hA, 8'h00);
  endtask

  initial begin
    rot_exp[0] = 8'h40; rot_exp[1] = 8'h20; rot_exp[2] = 8'h10; rot_exp[3] = 8'h08;
    rot_exp[4] = 8'h04; rot_exp[5] = 8'h02; rot_exp[6] = 8'h01; rot_exp[7] = 8'h80;

    clear_rom();
    rom[0] = mk(OP_CONFIG,    8'b0010_0101);
    rom[1] = mk(OP_INIT,      8'hFF);
    rom[2] = mk(OP_RUN,       8'h01);
    rom[3] = mk(OP_INIT_ADDR, 8'hFE);
    rom[4] = mk(OP_ADD_ADDR,  8'h03);
    rom[5] = mk(OP_ST_P,      8'h00);
    rom[6] = mk(OP_INIT,      8'h00);
    rom[7] = mk(OP_LD_P,      8'h00);
    rom[8] = mk(OP_RUN,       8'h00);
    rom[9] = mk(OP_HALT,      8'h00);

    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_p", P, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("p1_start_pc", pc, 0);
    check("p1_start_busy", busy, 1);
    tick();
    check("p1_config_pc", pc, 1);
    tick();
    check("p1_init_pc", pc, 2);
    check("p1_init_p", P, 8'hFF);
    check("p1_galois_next", P_next, 8'hDA);
    check("p1_galois_hd", hd, 3);
    tick();
    check("p1_run1_p", P, 8'hDA);
    check("p1_run1_pc", pc, 3);
    check("p1_run1_busy", busy, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("p1_start_ignored_pc", pc, 4);
    tick();
    check("p1_addr_wrap", dut.r_addr, 8'h01);
    check("p1_add_pc", pc, 5);
    tick();
    check("p1_stp_pc", pc, 6);
    tick();
    check("p1_init0_p", P, 8'h00);
    tick();
    check("p1_ldp_p", P, 8'hDA);
    check("p1_ldp_pc", pc, 8);
    check("p1_ldp_next", P_next, 8'h6D);
    tick();
    check("p1_run0_p", P, 8'h6D);
    check("p1_run0_pc", pc, 9);
    check("p1_run0_busy", busy, 1);
    tick();
    check("p1_halt_halted", halted, 1);
    check("p1_halt_busy", busy, 0);
    tick();
    check("p1_halt_hold_p", P, 8'h6D);
    check("p1_halt_hold", halted, 1);

    clear_rom();
    rom[0] = mk(OP_MODE,   8'h01);
    rom[1] = mk(OP_CONFIG, 8'h00);
    rom[2] = mk(OP_INIT,   8'h80);
    rom[3] = mk(OP_RUN,    8'h08);
    rom[4] = mk(OP_ST_HD,  8'h00);
    rom[5] = mk(OP_LD_P,   8'h00);
    rom[6] = mk(OP_HALT,   8'h00);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("p2_restart_halted", halted, 0);
    check("p2_restart_pc", pc, 0);
    tick();
    tick();
    tick();
    check("p2_init_p", P, 8'h80);
    check("p2_init_pc", pc, 3);
    check("p2_fib_next", P_next, 8'h40);
    check("p2_fib_hd", hd, 2);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("p2_rot_p%0d", k + 1), P, rot_exp[k]);
      check($sformatf("p2_rot_pc%0d", k + 1), pc, (k < 7) ? 3 : 4);
    end
    check("p2_sthd_hd", hd, 2);
    tick();
    tick();
    check("p2_ld_hd_p", P, 8'h02);
    check("p2_ld_hd_pc", pc, 6);
    tick();
    check("p2_halt", halted, 1);

    clear_rom();
    rom[0] = mk(OP_INIT, 8'h01);
    rom[1] = mk(OP_RUN,  8'h05);

    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("p3_init_p", P, 8'h01);
    check("p3_init_pc", pc, 1);
    tick();
    check("p3_step1_p", P, 8'h80);
    check("p3_step1_busy", busy, 1);
    check("p3_step1_pc", pc, 1);
    tick();
    check("p3_step2_p", P, 8'h40);
    rst_n = 1'b0;
    #1;
    check("p3_rst_p", P, 0);
    check("p3_rst_pc", pc, 0);
    check("p3_rst_busy", busy, 0);
    check("p3_rst_halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("p3_idle_p", P, 0);
    check("p3_idle_pc", pc, 0);
    check("p3_idle_busy", busy, 0);
    check("p3_idle_halted", halted, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
